// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, the ALU drive/return lines and the tagged response channel.
// master = requesters, consumer and ALU; slave = the arbiter.
interface alu_arbiter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CTL_W = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [CTL_W-1:0] req0_ctl;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [CTL_W-1:0] req1_ctl;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic [CTL_W-1:0] alu_ctl;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_err;
   logic             busy;

   modport master (
      output req0_valid, req0_ctl, req0_a, req0_b,
      output req1_valid, req1_ctl, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_ctl, alu_a, alu_b,
      output alu_result, alu_zero,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_ctl, req0_a, req0_b,
      input  req1_valid, req1_ctl, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_ctl, alu_a, alu_b,
      input  alu_result, alu_zero,
      output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters; one op in flight,
// result returned on a tagged response channel with backpressure.
module alu_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CTL_W = 4
) (
   input logic          clk,
   input logic          reset,
   alu_arbiter_if.slave bus
);
   localparam logic [CTL_W-1:0] CTL_AND = CTL_W'(0);
   localparam logic [CTL_W-1:0] CTL_OR  = CTL_W'(1);
   localparam logic [CTL_W-1:0] CTL_ADD = CTL_W'(2);
   localparam logic [CTL_W-1:0] CTL_SUB = CTL_W'(6);
   localparam logic [CTL_W-1:0] CTL_SLT = CTL_W'(7);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             err_q, err_d;
   logic [CTL_W-1:0] alu_ctl_q, alu_ctl_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_err_q, rsp_err_d;
   logic             busy_q, busy_d;

   logic             grant0, grant1;
   logic [CTL_W-1:0] sel_ctl;
   logic [WIDTH-1:0] sel_a, sel_b;

   function automatic logic ctl_legal(input logic [CTL_W-1:0] c);
      return (c == CTL_AND) || (c == CTL_OR) || (c == CTL_ADD) ||
             (c == CTL_SUB) || (c == CTL_SLT);
   endfunction

   // Sole valid requester wins; on contention the one not granted last time wins.
   always_comb begin
      grant0  = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
      sel_ctl = grant1 ? bus.req1_ctl : bus.req0_ctl;
      sel_a   = grant1 ? bus.req1_a   : bus.req0_a;
      sel_b   = grant1 ? bus.req1_b   : bus.req0_b;
   end

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      err_d          = err_q;
      alu_ctl_d      = alu_ctl_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_id_d       = rsp_id_q;
      rsp_result_d   = rsp_result_q;
      rsp_zero_d     = rsp_zero_q;
      rsp_err_d      = rsp_err_q;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;

      unique case (state_q)
         IDLE: begin
            bus.req0_ready = grant0;
            bus.req1_ready = grant1;
            if (grant0 || grant1) begin
               // Unsupported codes park the ALU on AND; its output is discarded anyway.
               alu_ctl_d    = ctl_legal(sel_ctl) ? sel_ctl : CTL_AND;
               err_d        = !ctl_legal(sel_ctl);
               alu_a_d      = sel_a;
               alu_b_d      = sel_b;
               last_grant_d = grant1;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = last_grant_q;
            rsp_result_d = err_q ? '0 : bus.alu_result;
            rsp_zero_d   = !err_q && bus.alu_zero;
            rsp_err_d    = err_q;
            state_d      = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         err_q        <= 1'b0;
         alu_ctl_q    <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
         alu_ctl_q    <= alu_ctl_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.alu_ctl    = alu_ctl_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU hanging off the interface.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(32), .CTL_W(4)) bus ();

   alu_arbiter #(.WIDTH(32), .CTL_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural ALU; unknown codes return a marker that must never reach rsp_result.
   always_comb begin
      case (bus.alu_ctl)
         4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
         4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
         4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
         4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
         4'b0111: bus.alu_result = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
         default: bus.alu_result = 32'hDEAD_BEEF;
      endcase
      bus.alu_zero = (bus.alu_result == 32'd0);
   end

   task automatic do_reset();
      reset = 1'b1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
      bus.req0_ctl = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
      bus.req1_ctl = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Issues one op, waits for its response and pops it; entered and left at 1 time unit after an edge.
   task automatic run_op(input bit who, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         output logic id, output logic [31:0] res, output logic z, output logic err);
      int cnt;
      if (!who) begin bus.req0_valid = 1'b1; bus.req0_ctl = ctl; bus.req0_a = a; bus.req0_b = b; end
      else      begin bus.req1_valid = 1'b1; bus.req1_ctl = ctl; bus.req1_a = a; bus.req1_b = b; end
      #1;
      cnt = 0;
      while (((who ? bus.req1_ready : bus.req0_ready) !== 1'b1) && cnt < 10) begin
         @(posedge clk); #2; cnt++;
      end
      n_checks++;
      if (cnt >= 10) begin n_fail++; $display("FAIL op_accept: requester %0d never saw ready within 10 cycles", who); end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      cnt = 0;
      while (bus.rsp_valid !== 1'b1 && cnt < 10) begin @(posedge clk); #1; cnt++; end
      n_checks++;
      if (cnt != 1) begin n_fail++; $display("FAIL op_latency: got %0d extra edges, expected 1", cnt); end
      id = bus.rsp_id; res = bus.rsp_result; z = bus.rsp_zero; err = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.rsp_result !== 32'd0 || bus.rsp_id !== 1'b0 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_rsp_fields: got res=%h id=%b z=%b e=%b expected all 0", bus.rsp_result, bus.rsp_id, bus.rsp_zero, bus.rsp_err); end
      n_checks++; if (bus.alu_ctl !== 4'd0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
         n_fail++; $display("FAIL rst_alu_regs: got ctl=%h a=%h b=%h expected 0", bus.alu_ctl, bus.alu_a, bus.alu_b); end
      n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_ready_idle: got %b%b expected 00", bus.req0_ready, bus.req1_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_add();
      bus.req0_valid = 1'b1; bus.req0_ctl = 4'b0010; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
      #1;
      n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b expected 1", bus.req0_ready); end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      n_checks++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL add_exec: got busy=%b rsp_valid=%b expected 1/0", bus.busy, bus.rsp_valid); end
      n_checks++; if (bus.alu_ctl !== 4'b0010 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
         n_fail++; $display("FAIL add_alu_drive: got ctl=%h a=%0d b=%0d expected 2/5/7", bus.alu_ctl, bus.alu_a, bus.alu_b); end
      @(posedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_rsp_valid: got %b expected 1", bus.rsp_valid); end
      n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL add_rsp_id: got %b expected 0", bus.rsp_id); end
      n_checks++; if (bus.rsp_result !== 32'd12) begin n_fail++; $display("FAIL add_rsp_result: got %0d expected 12", bus.rsp_result); end
      n_checks++; if (bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL add_rsp_flags: got z=%b e=%b expected 0/0", bus.rsp_zero, bus.rsp_err); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL add_release: got rsp_valid=%b busy=%b expected 0/0", bus.rsp_valid, bus.busy); end
   endtask

   task automatic test_round_robin();
      logic [31:0] a0 [2] = '{32'd10, 32'd30};
      logic [31:0] b0 [2] = '{32'd3,  32'd8};
      logic [31:0] a1 [2] = '{32'd20, 32'd40};
      logic [31:0] b1 [2] = '{32'd5,  32'd1};
      logic        exp_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] exp_res [4] = '{32'd7, 32'd15, 32'd22, 32'd39};
      int g0 = 0, g1 = 0, resp = 0;
      logic h0, h1;
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_ctl = 4'b0110; bus.req0_a = a0[0]; bus.req0_b = b0[0];
      bus.req1_valid = 1'b1; bus.req1_ctl = 4'b0110; bus.req1_a = a1[0]; bus.req1_b = b1[0];
      bus.rsp_ready  = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         h0 = bus.req0_ready; h1 = bus.req1_ready;
         @(posedge clk); #1;
         if (h0) begin g0++; if (g0 < 2) begin bus.req0_a = a0[g0]; bus.req0_b = b0[g0]; end else bus.req0_valid = 1'b0; end
         if (h1) begin g1++; if (g1 < 2) begin bus.req1_a = a1[g1]; bus.req1_b = b1[g1]; end else bus.req1_valid = 1'b0; end
         if (bus.rsp_valid === 1'b1) begin
            if (resp < 4) begin
               n_checks++; if (bus.rsp_id !== exp_id[resp]) begin
                  n_fail++; $display("FAIL rr_id[%0d]: got %b expected %b", resp, bus.rsp_id, exp_id[resp]); end
               n_checks++; if (bus.rsp_result !== exp_res[resp]) begin
                  n_fail++; $display("FAIL rr_result[%0d]: got %0d expected %0d", resp, bus.rsp_result, exp_res[resp]); end
            end
            resp++;
         end
      end
      bus.rsp_ready = 1'b0;
      n_checks++; if (resp != 4) begin n_fail++; $display("FAIL rr_count: got %0d responses expected 4", resp); end
   endtask

   task automatic test_flags();
      logic id, z, e;
      logic [31:0] r;
      run_op(1'b0, 4'b0111, 32'd3, 32'd9, id, r, z, e);
      n_checks++; if (r !== 32'd1 || z !== 1'b0 || e !== 1'b0) begin
         n_fail++; $display("FAIL slt_3_9: got r=%0d z=%b e=%b expected 1/0/0", r, z, e); end
      run_op(1'b1, 4'b0111, 32'd9, 32'd3, id, r, z, e);
      n_checks++; if (r !== 32'd0 || z !== 1'b1 || id !== 1'b1) begin
         n_fail++; $display("FAIL slt_9_3: got r=%0d z=%b id=%b expected 0/1/1", r, z, id); end
      run_op(1'b0, 4'b0110, 32'd4, 32'd4, id, r, z, e);
      n_checks++; if (r !== 32'd0 || z !== 1'b1 || id !== 1'b0) begin
         n_fail++; $display("FAIL sub_4_4: got r=%0d z=%b id=%b expected 0/1/0", r, z, id); end
      run_op(1'b1, 4'b0000, 32'h0000_00F0, 32'h0000_000F, id, r, z, e);
      n_checks++; if (r !== 32'd0 || z !== 1'b1 || e !== 1'b0) begin
         n_fail++; $display("FAIL and_f0_0f: got r=%h z=%b e=%b expected 0/1/0", r, z, e); end
   endtask

   task automatic test_backpressure();
      bus.req0_valid = 1'b1; bus.req0_ctl = 4'b0010; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
      #1;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_ctl = 4'b0010; bus.req1_a = 32'd100; bus.req1_b = 32'd23;
      #1;
      n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_exec_ready: got %b expected 0", bus.req1_ready); end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd3 || bus.rsp_id !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b r=%0d id=%b expected 1/3/0", i, bus.rsp_valid, bus.rsp_result, bus.rsp_id); end
         n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL bp_stall[%0d]: got rdy=%b%b busy=%b expected 00/1", i, bus.req0_ready, bus.req1_ready, bus.busy); end
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      #1;
      n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_same_cycle_accept: got %b expected 0", bus.req1_ready); end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req1_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got v=%b busy=%b rdy1=%b expected 0/0/1", bus.rsp_valid, bus.busy, bus.req1_ready); end
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_req1_accept: got busy=%b expected 1", bus.busy); end
      @(posedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'd123) begin
         n_fail++; $display("FAIL bp_req1_rsp: got v=%b id=%b r=%0d expected 1/1/123", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_illegal_ctl();
      logic id, z, e;
      logic [31:0] r;
      bus.req1_valid = 1'b1; bus.req1_ctl = 4'b0011; bus.req1_a = 32'd5; bus.req1_b = 32'd6;
      #1;
      n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %b expected 1", bus.req1_ready); end
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      n_checks++; if (bus.alu_ctl !== 4'b0000) begin n_fail++; $display("FAIL ill_alu_ctl: got %b expected 0000", bus.alu_ctl); end
      @(posedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_id !== 1'b1) begin
         n_fail++; $display("FAIL ill_rsp: got v=%b err=%b id=%b expected 1/1/1", bus.rsp_valid, bus.rsp_err, bus.rsp_id); end
      n_checks++; if (bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b0) begin
         n_fail++; $display("FAIL ill_masked: got r=%h z=%b expected 0/0", bus.rsp_result, bus.rsp_zero); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      run_op(1'b1, 4'b0001, 32'h1, 32'h2, id, r, z, e);
      n_checks++; if (r !== 32'd3 || e !== 1'b0 || z !== 1'b0) begin
         n_fail++; $display("FAIL or_after_ill: got r=%0d e=%b z=%b expected 3/0/0", r, e, z); end
   endtask

   task automatic test_reset_mid_op();
      bus.req1_valid = 1'b1; bus.req1_ctl = 4'b0010; bus.req1_a = 32'd9; bus.req1_b = 32'd9;
      #1;
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL rmid_state: got busy=%b v=%b expected 0/0", bus.busy, bus.rsp_valid); end
      n_checks++; if (bus.alu_a !== 32'd0 || bus.alu_ctl !== 4'd0) begin
         n_fail++; $display("FAIL rmid_alu_regs: got a=%0d ctl=%h expected 0/0", bus.alu_a, bus.alu_ctl); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_rsp[%0d]: got %b expected 0", i, bus.rsp_valid); end
      end
      bus.req0_valid = 1'b1; bus.req0_ctl = 4'b0010; bus.req0_a = 32'd2; bus.req0_b = 32'd3;
      bus.req1_valid = 1'b1; bus.req1_ctl = 4'b0010; bus.req1_a = 32'd7; bus.req1_b = 32'd7;
      #1;
      n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         n_fail++; $display("FAIL rmid_first_grant: got rdy=%b%b expected 10", bus.req0_ready, bus.req1_ready); end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd5) begin
         n_fail++; $display("FAIL rmid_rsp: got v=%b id=%b r=%0d expected 1/0/5", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_flags();
      test_backpressure();
      test_illegal_ctl();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
